// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter/scheduler: request types, FSM states
// and default widths.
package mem_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ROW_W     = 4;
  localparam int DEF_COL_W     = 4;
  localparam int DEF_TIMESTEPS = 10;
  localparam int DEF_T_W       = 4;

  typedef enum logic [1:0] {
    VPOT   = 2'd0,
    SPIKE  = 2'd1,
    FILTER = 2'd2
  } mem_type_e;

  // Encoding 3 is accepted at the port but never reaches memory.
  localparam logic [1:0] TYPE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RSP  = 3'd2,
    ADV_DRAIN = 3'd3,
    ADV_SEND  = 3'd4,
    DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: one-hot grant for the first active
// request found at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_sched.sv
// Single-outstanding memory arbiter for N requesters with a timestep
// advance sequencer that drains traffic before publishing a new timestep.
module mem_arbiter_sched
  import mem_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ROW_W     = DEF_ROW_W,
  parameter int COL_W     = DEF_COL_W,
  parameter int TIMESTEPS = DEF_TIMESTEPS,
  parameter int T_W       = DEF_T_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_rw,
  input  logic [2*N_REQ-1:0]      req_type,
  input  logic [ROW_W*N_REQ-1:0]  req_row,
  input  logic [COL_W*N_REQ-1:0]  req_col,
  input  logic [DATA_W*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_rw,
  output logic [1:0]              cmd_type,
  output logic [ROW_W-1:0]        cmd_row,
  output logic [COL_W-1:0]        cmd_col,
  output logic [DATA_W-1:0]       cmd_wdata,
  input  logic                    mrsp_valid,
  input  logic [DATA_W-1:0]       mrsp_data,
  input  logic                    ts_adv,
  output logic                    t_valid,
  input  logic                    t_ready,
  output logic [T_W-1:0]          t_value,
  output logic [T_W-1:0]          cur_t,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_reg, state_next;
  logic [PTR_W-1:0]    ptr_reg;
  logic                adv_pend_reg;
  logic                err_reg;
  logic [T_W-1:0]      cur_t_reg;
  logic                cap_rw_reg;
  logic [1:0]          cap_type_reg;
  logic [ROW_W-1:0]    cap_row_reg;
  logic [COL_W-1:0]    cap_col_reg;
  logic [DATA_W-1:0]   cap_wdata_reg;
  logic [N_REQ-1:0]    cap_owner_reg;
  logic [N_REQ-1:0]    rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_data_reg;

  logic [1:0]          type_arr  [N_REQ];
  logic [ROW_W-1:0]    row_arr   [N_REQ];
  logic [COL_W-1:0]    col_arr   [N_REQ];
  logic [DATA_W-1:0]   wdata_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign type_arr[gi]  = req_type[2*gi +: 2];
      assign row_arr[gi]   = req_row[ROW_W*gi +: ROW_W];
      assign col_arr[gi]   = req_col[COL_W*gi +: COL_W];
      assign wdata_arr[gi] = req_wdata[DATA_W*gi +: DATA_W];
    end
  endgenerate

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  win_idx;
  logic              win_rw;
  logic [1:0]        win_type;
  logic [ROW_W-1:0]  win_row;
  logic [COL_W-1:0]  win_col;
  logic [DATA_W-1:0] win_wdata;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_rr (
    .req  (req_valid),
    .ptr  (ptr_reg),
    .grant(grant)
  );

  always_comb begin
    win_idx   = '0;
    win_rw    = 1'b0;
    win_type  = '0;
    win_row   = '0;
    win_col   = '0;
    win_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_idx   = PTR_W'(i);
        win_rw    = req_rw[i];
        win_type  = type_arr[i];
        win_row   = row_arr[i];
        win_col   = col_arr[i];
        win_wdata = wdata_arr[i];
      end
    end
  end

  // A same-cycle ts_adv already outranks any grant in IDLE.
  logic arb_fire;
  logic win_illegal;
  logic t_last;

  assign arb_fire    = (state_reg == IDLE) && !(adv_pend_reg || ts_adv) && (|req_valid);
  assign win_illegal = (win_type == TYPE_ILLEGAL);
  assign t_value     = cur_t_reg + 1'b1;
  assign t_last      = (t_value == T_W'(TIMESTEPS));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (adv_pend_reg || ts_adv)     state_next = ADV_DRAIN;
        else if (arb_fire && !win_illegal) state_next = ISSUE;
      end
      ISSUE:     if (cmd_ready)  state_next = cap_rw_reg ? IDLE : WAIT_RSP;
      WAIT_RSP:  if (mrsp_valid) state_next = IDLE;
      ADV_DRAIN: state_next = ADV_SEND;
      ADV_SEND:  if (t_ready)    state_next = t_last ? DONE : IDLE;
      DONE:      state_next = DONE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = arb_fire ? grant : '0;
    cmd_valid = (state_reg == ISSUE);
    t_valid   = (state_reg == ADV_SEND);
    busy      = (state_reg != IDLE) && (state_reg != DONE);
    done      = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg       <= '0;
      adv_pend_reg  <= 1'b0;
      err_reg       <= 1'b0;
      cur_t_reg     <= '0;
      cap_rw_reg    <= 1'b0;
      cap_type_reg  <= '0;
      cap_row_reg   <= '0;
      cap_col_reg   <= '0;
      cap_wdata_reg <= '0;
      cap_owner_reg <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= '0;
      if (ts_adv && state_reg != DONE) adv_pend_reg <= 1'b1;
      // Completion clears the pending flag, absorbing any duplicate pulses.
      if (state_reg == ADV_SEND && t_ready) begin
        cur_t_reg    <= t_value;
        adv_pend_reg <= 1'b0;
      end
      if (arb_fire) begin
        ptr_reg <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        if (win_illegal) begin
          err_reg <= 1'b1;
        end else begin
          cap_rw_reg    <= win_rw;
          cap_type_reg  <= win_type;
          cap_row_reg   <= win_row;
          cap_col_reg   <= win_col;
          cap_wdata_reg <= win_wdata;
          cap_owner_reg <= grant;
        end
      end
      if (state_reg == WAIT_RSP && mrsp_valid) begin
        rsp_valid_reg <= cap_owner_reg;
        rsp_data_reg  <= (cap_type_reg == SPIKE) ?
                         {{(DATA_W-1){1'b0}}, mrsp_data[0]} : mrsp_data;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign cmd_rw    = cap_rw_reg;
  assign cmd_type  = cap_type_reg;
  assign cmd_row   = cap_row_reg;
  assign cmd_col   = cap_col_reg;
  assign cmd_wdata = cap_wdata_reg;
  assign cur_t     = cur_t_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_arbiter_sched.sv
// Self-checking bench for mem_arbiter_sched: directed scenarios plus random
// traffic scored against a transaction-level round-robin/timestep model.
module tb_mem_arbiter_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int TS = 10;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_rw, rsp_valid;
  logic [2*N-1:0]  req_type;
  logic [RW*N-1:0] req_row;
  logic [CW*N-1:0] req_col;
  logic [DW*N-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, cmd_wdata, mrsp_data;
  logic            cmd_valid, cmd_ready, cmd_rw, mrsp_valid;
  logic [1:0]      cmd_type;
  logic [RW-1:0]   cmd_row;
  logic [CW-1:0]   cmd_col;
  logic            ts_adv, t_valid, t_ready, busy, done, err;
  logic [TW-1:0]   t_value, cur_t;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter_sched #(
    .N_REQ(N), .DATA_W(DW), .ROW_W(RW), .COL_W(CW), .TIMESTEPS(TS), .T_W(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_type(req_type), .req_row(req_row), .req_col(req_col),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_type(cmd_type), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_wdata(cmd_wdata), .mrsp_valid(mrsp_valid), .mrsp_data(mrsp_data),
    .ts_adv(ts_adv), .t_valid(t_valid), .t_ready(t_ready), .t_value(t_value),
    .cur_t(cur_t), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v == N'(1 << k)) return k;
    return -1;
  endfunction

  task automatic clear_inputs();
    req_valid = '0; req_rw = '0; req_type = '0; req_row = '0; req_col = '0;
    req_wdata = '0; cmd_ready = 0; mrsp_valid = 0; mrsp_data = '0;
    ts_adv = 0; t_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    n_cmp++;
    if ({req_ready, rsp_valid, cmd_valid, t_valid, busy, done, err} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0",
               {req_ready, rsp_valid, cmd_valid, t_valid, busy, done, err});
    end
    n_cmp++;
    if (cur_t !== '0 || rsp_data !== '0) begin
      n_err++; $display("FAIL reset_data: cur_t=%0d rsp_data=%h want 0/0", cur_t, rsp_data);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    int ncmd = 0;
    @(negedge clk);
    req_valid = 4'b0010; req_rw = '0; req_type[2 +: 2] = 2'd2;
    req_row[RW +: RW] = 4'd2; req_col[CW +: CW] = 4'd1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rd_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0; cmd_ready = 1; #1;
    n_cmp++;
    if ({cmd_valid, cmd_rw, cmd_type, cmd_row, cmd_col} !== {1'b1, 1'b0, 2'd2, 4'd2, 4'd1}) begin
      n_err++; $display("FAIL rd_cmd: got v=%b rw=%b ty=%0d r=%0d c=%0d want 1 0 2 2 1",
                        cmd_valid, cmd_rw, cmd_type, cmd_row, cmd_col);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmd_ready = 0; mrsp_valid = (c == 2); mrsp_data = 8'h05; #1;
      if (cmd_valid) ncmd++;
      n_cmp++;
      if (rsp_valid !== '0) begin n_err++; $display("FAIL rd_early_rsp: got %b want 0000", rsp_valid); end
    end
    @(negedge clk);
    mrsp_valid = 0; #1;
    n_cmp++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 8'h05) begin
      n_err++; $display("FAIL rd_rsp: got %b/%h want 0010/05", rsp_valid, rsp_data);
    end
    n_cmp++;
    if (ncmd != 0) begin n_err++; $display("FAIL rd_one_cmd: extra cmd cycles %0d want 0", ncmd); end
    @(negedge clk); #1;
    n_cmp++;
    if (rsp_valid !== '0) begin n_err++; $display("FAIL rd_rsp_pulse: got %b want 0000", rsp_valid); end
    $display("test_single_read done");
  endtask

  task automatic test_round_robin();
    int last = -1, ng = 0, w;
    int hist[$];
    logic [DW-1:0] exp_wd = '0;
    logic [N-1:0] win;
    do_reset();
    for (int c = 0; c < 40 && ng < 5; c++) begin
      @(negedge clk);
      req_valid = 4'hF; req_rw = 4'hF; req_type = '0;
      req_wdata = {8'h44, 8'h33, 8'h22, 8'h11}; cmd_ready = 1; #1;
      if (cmd_valid) begin
        n_cmp++;
        if (cmd_wdata !== exp_wd) begin n_err++; $display("FAIL rr_wdata: got %h want %h", cmd_wdata, exp_wd); end
      end
      if (req_ready != '0) begin
        w = (last < 0) ? 0 : (last + 1) % N;
        n_cmp++;
        if (req_ready !== N'(1 << w)) begin n_err++; $display("FAIL rr_order: got %b want %b", req_ready, N'(1 << w)); end
        $display("rr grant %0d: %b", ng, req_ready);
        last = w; ng++; exp_wd = DW'(8'h11 * (w + 1));
        hist.push_back(oh_idx(req_ready));
        if (hist.size() >= 4) begin
          win = '0;
          for (int k = hist.size() - 4; k < hist.size(); k++) if (hist[k] >= 0) win[hist[k]] = 1'b1;
          n_cmp++;
          if (win !== 4'hF) begin n_err++; $display("FAIL rr_window: got %b want 1111", win); end
        end
      end
    end
    n_cmp++;
    if (ng < 5) begin n_err++; $display("FAIL rr_timeout: got %0d grants want 5", ng); end
    clear_inputs();
    $display("test_round_robin done");
  endtask

  task automatic test_adv_mid_read();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_rw = '0; req_type = '0; req_row = '1; #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL adv_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b1110; cmd_ready = 1; #1;
    @(negedge clk);
    cmd_ready = 0; ts_adv = 1; #1;
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== '0) begin
      n_err++; $display("FAIL adv_wait: busy=%b ready=%b want 1/0000", busy, req_ready);
    end
    @(negedge clk);
    ts_adv = 0; mrsp_valid = 1; mrsp_data = 8'h3C; #1;
    @(negedge clk);
    mrsp_valid = 0; ts_adv = 1; #1;
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 8'h3C || req_ready !== '0) begin
      n_err++; $display("FAIL adv_rsp: rsp=%b data=%h ready=%b want 0001/3c/0000", rsp_valid, rsp_data, req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ts_adv = 0; t_ready = (c == 2); #1;
      n_cmp++;
      if (req_ready !== '0 || cmd_valid !== 1'b0) begin
        n_err++; $display("FAIL adv_no_grant: ready=%b cmd=%b want 0000/0", req_ready, cmd_valid);
      end
      if (c >= 1) begin
        n_cmp++;
        if (t_valid !== 1'b1 || t_value !== 4'd1) begin
          n_err++; $display("FAIL adv_tvalid: v=%b val=%0d want 1/1", t_valid, t_value);
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      t_ready = 0; req_valid = '0; #1;
      n_cmp++;
      if (cur_t !== 4'd1 || t_valid !== 1'b0) begin
        n_err++; $display("FAIL adv_cur_t: cur_t=%0d t_valid=%b want 1/0", cur_t, t_valid);
      end
    end
    $display("test_adv_mid_read done");
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    ts_adv = 1; req_valid = 4'b0100; req_rw = 4'b0100; req_type = '0; #1;
    n_cmp++;
    if (req_ready !== '0) begin n_err++; $display("FAIL sim_adv_wins: got %b want 0000", req_ready); end
    @(negedge clk);
    ts_adv = 0; #1;
    @(negedge clk);
    t_ready = 1; #1;
    n_cmp++;
    if (t_valid !== 1'b1 || t_value !== 4'd2 || req_ready !== '0) begin
      n_err++; $display("FAIL sim_tvalid: v=%b val=%0d ready=%b want 1/2/0000", t_valid, t_value, req_ready);
    end
    @(negedge clk);
    t_ready = 0; #1;
    n_cmp++;
    if (req_ready !== 4'b0100 || cur_t !== 4'd2) begin
      n_err++; $display("FAIL sim_then_grant: ready=%b cur_t=%0d want 0100/2", req_ready, cur_t);
    end
    @(negedge clk);
    req_valid = '0; cmd_ready = 1; #1;
    @(negedge clk);
    cmd_ready = 0; #1;
    $display("test_simultaneous done");
  endtask

  task automatic test_illegal();
    int ncmd = 0;
    @(negedge clk);
    req_valid = 4'b1000; req_type[6 +: 2] = 2'd3; #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL ill_grant: got %b want 1000", req_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = '0; cmd_ready = 1; #1;
      if (cmd_valid || busy) ncmd++;
    end
    n_cmp++;
    if (err !== 1'b1 || ncmd != 0) begin
      n_err++; $display("FAIL ill_err: err=%b cmd_cycles=%0d want 1/0", err, ncmd);
    end
    cmd_ready = 0;
    $display("test_illegal done");
  endtask

  task automatic test_random();
    int mptr = 0, exp_w, grants = 0, delay = 0, model_t = 0, adv_age = 0;
    bit outst = 0, issue_m = 0, adv_m = 0, rd_wait = 0, rsp_due = 0, mrsp_now;
    logic [N-1:0] exp_rr, drop = '0, g_owner = '0;
    logic g_rw = 0;
    logic [1:0] g_type = '0;
    logic [RW-1:0] g_row = '0;
    logic [CW-1:0] g_col = '0;
    logic [DW-1:0] g_wd = '0, exp_data = '0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      mrsp_valid = 0; mrsp_now = 0;
      if (rd_wait) begin
        if (delay == 0) begin
          mrsp_valid = 1; mrsp_data = DW'($urandom); mrsp_now = 1;
        end else delay--;
      end
      req_valid = req_valid & ~drop; drop = '0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[i] = 1; req_rw[i] = 1'($urandom);
          req_type[2*i +: 2] = 2'($urandom_range(0, 2));
          req_row[RW*i +: RW] = RW'($urandom); req_col[CW*i +: CW] = CW'($urandom);
          req_wdata[DW*i +: DW] = DW'($urandom);
        end
      end
      ts_adv = !adv_m && model_t < 8 && $urandom_range(0, 24) == 0;
      cmd_ready = 1'($urandom); t_ready = 1'($urandom);
      #1;
      n_cmp++;
      if (rsp_valid !== (rsp_due ? g_owner : '0) || (rsp_due && rsp_data !== exp_data)) begin
        n_err++; $display("FAIL rnd_rsp: cyc %0d got %b/%h want %b/%h", cyc, rsp_valid, rsp_data,
                          rsp_due ? g_owner : '0, exp_data);
      end
      exp_w = rr_pick(req_valid, mptr);
      exp_rr = (!outst && !adv_m && !ts_adv && exp_w >= 0) ? N'(1 << exp_w) : '0;
      n_cmp++;
      if (req_ready !== exp_rr) begin
        n_err++; $display("FAIL rnd_grant: cyc %0d got %b want %b", cyc, req_ready, exp_rr);
      end
      n_cmp++;
      if (cur_t !== TW'(model_t) || (t_valid && (!adv_m || outst || t_value !== TW'(model_t + 1)))) begin
        n_err++; $display("FAIL rnd_time: cyc %0d cur_t=%0d t_valid=%b t_value=%0d want cur_t %0d",
                          cyc, cur_t, t_valid, t_value, model_t);
      end
      n_cmp++;
      if (cmd_valid !== issue_m || (issue_m && ({cmd_rw, cmd_type, cmd_row, cmd_col} !==
          {g_rw, g_type, g_row, g_col} || (g_rw && cmd_wdata !== g_wd)))) begin
        n_err++; $display("FAIL rnd_cmd: cyc %0d got v=%b %b/%0d/%0d/%0d/%h want v=%b %b/%0d/%0d/%0d/%h",
                          cyc, cmd_valid, cmd_rw, cmd_type, cmd_row, cmd_col, cmd_wdata,
                          issue_m, g_rw, g_type, g_row, g_col, g_wd);
      end
      adv_age = adv_m ? adv_age + 1 : 0;
      if (adv_age > 30) begin
        n_cmp++; n_err++; adv_age = 0;
        $display("FAIL rnd_adv_timeout: cyc %0d t_valid never completed", cyc);
      end
      if (issue_m && cmd_ready) begin
        issue_m = 0;
        if (g_rw) outst = 0;
        else begin rd_wait = 1; delay = $urandom_range(0, 3); end
      end
      rsp_due = mrsp_now;
      if (mrsp_now) begin
        outst = 0; rd_wait = 0;
        exp_data = (g_type == 2'd1) ? {7'b0, mrsp_data[0]} : mrsp_data;
      end
      if (exp_rr != '0) begin
        $display("rnd txn %0d: grant req%0d rw=%b type=%0d", grants, exp_w, req_rw[exp_w], req_type[2*exp_w +: 2]);
        outst = 1; issue_m = 1; g_owner = exp_rr; drop = exp_rr;
        g_rw = req_rw[exp_w]; g_type = req_type[2*exp_w +: 2];
        g_row = req_row[RW*exp_w +: RW]; g_col = req_col[CW*exp_w +: CW];
        g_wd = req_wdata[DW*exp_w +: DW];
        mptr = (exp_w + 1) % N; grants++;
      end
      if (t_valid && t_ready) begin model_t++; adv_m = 0; end
      if (ts_adv) adv_m = 1;
    end
    n_cmp++;
    if (grants < 50) begin n_err++; $display("FAIL rnd_liveness: got %0d grants want >= 50", grants); end
    clear_inputs();
    $display("test_random done: %0d grants", grants);
  endtask

  task automatic test_completion();
    bit found;
    do_reset();
    req_valid = 4'hF; req_rw = 4'hF; cmd_ready = 1;
    for (int k = 1; k <= TS; k++) begin
      found = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        t_ready = 0; ts_adv = (c == 0); #1;
        if (t_valid) begin
          n_cmp++;
          if (t_value !== TW'(k)) begin n_err++; $display("FAIL done_tvalue: got %0d want %0d", t_value, k); end
          t_ready = 1; found = 1;
          break;
        end
      end
      if (!found) begin n_cmp++; n_err++; $display("FAIL done_timeout: advance %0d never reached t_valid", k); end
    end
    @(negedge clk);
    t_ready = 0; ts_adv = 0; #1;
    n_cmp++;
    if (done !== 1'b1 || cur_t !== TW'(TS)) begin
      n_err++; $display("FAIL done_flag: done=%b cur_t=%0d want 1/%0d", done, cur_t, TS);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ts_adv = (c == 1); t_ready = 1; #1;
      n_cmp++;
      if ({req_ready, cmd_valid, t_valid, busy} !== '0 || done !== 1'b1 || cur_t !== TW'(TS)) begin
        n_err++; $display("FAIL done_terminal: ready=%b cmd=%b tv=%b busy=%b done=%b cur_t=%0d want 0/0/0/0/1/%0d",
                          req_ready, cmd_valid, t_valid, busy, done, cur_t, TS);
      end
    end
    clear_inputs();
    $display("test_completion done");
  endtask

  task automatic test_reset_in_issue();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_rw = '0; req_type = '0; #1;
    @(negedge clk);
    req_valid = '0; cmd_ready = 0; #1;
    n_cmp++;
    if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL rst_issue_pre: cmd_valid=%b want 1", cmd_valid); end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0; mrsp_valid = 1; mrsp_data = 8'hFF; #1;
    n_cmp++;
    if ({req_ready, cmd_valid, t_valid, busy, done, err, rsp_valid} !== '0 || cur_t !== '0) begin
      n_err++; $display("FAIL rst_issue_out: ctrl=%b cur_t=%0d want 0/0",
                        {req_ready, cmd_valid, t_valid, busy, done, err, rsp_valid}, cur_t);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mrsp_valid = 0; #1;
      n_cmp++;
      if (rsp_valid !== '0 || rsp_data !== '0 || busy !== 1'b0 || cur_t !== '0) begin
        n_err++; $display("FAIL rst_stray_rsp: rsp=%b data=%h busy=%b cur_t=%0d want 0/00/0/0",
                          rsp_valid, rsp_data, busy, cur_t);
      end
    end
    $display("test_reset_in_issue done");
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_adv_mid_read();
    test_simultaneous();
    test_illegal();
    test_random();
    test_completion();
    test_reset_in_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
